// File: rtl/synthesijer_fp32_pkg.sv
// Shared single-precision helpers for the native FP32 subtract core.
package synthesijer_fp32_pkg;

  localparam int          LATENCY  = 4;
  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] POS_INF  = 32'h7F800000;
  localparam logic [31:0] NEG_INF  = 32'hFF800000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
  } fp32_unpacked_t;

  // Denormals are flushed to a signed zero: exponent 0 yields mantissa 0.
  function automatic fp32_unpacked_t unpack(input logic [31:0] v);
    fp32_unpacked_t u;
    u.sign    = v[31];
    u.exp     = v[30:23];
    u.is_nan  = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    u.is_inf  = (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
    u.is_zero = (v[30:23] == 8'h00);
    u.mant    = u.is_zero ? 24'd0 : {1'b1, v[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/synthesijer_lzc28.sv
// Combinational leading-zero counter over 28 bits; all-zero input gives 28.
module synthesijer_lzc28 (
  input  logic [27:0] din,
  output logic [4:0]  cnt
);

  // Highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    cnt = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (din[i]) cnt = 5'(27 - i);
    end
  end

endmodule

// File: rtl/synthesijer_fsub32_core.sv
// IEEE-754 single-precision subtractor (a - b) with an AXI-Stream operand join,
// an input register and a four-stage arithmetic pipeline. FTZ, round-nearest-even.
module synthesijer_fsub32_core
  import synthesijer_fp32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_a_tvalid,
  output logic        s_axis_a_tready,
  input  logic [31:0] s_axis_b_tdata,
  input  logic        s_axis_b_tvalid,
  output logic        s_axis_b_tready,
  output logic [31:0] m_axis_result_tdata,
  output logic        m_axis_result_tvalid
);

  localparam logic signed [9:0] EMAX = 10'(EXP_MAX);

  // Round the 27-bit normalized magnitude (hidden bit at 26, G/R/S in [2:0])
  // to nearest-even, renormalize a rounding carry, then saturate to Inf or flush.
  function automatic logic [31:0] round_pack(input logic s,
                                             input logic signed [9:0] e,
                                             input logic [26:0] n);
    logic [24:0]       m;
    logic              up;
    logic signed [9:0] er;
    logic [31:0]       r;
    up = n[2] & ((|n[1:0]) | n[3]);
    m  = {1'b0, n[26:3]} + {24'd0, up};
    er = e;
    if (m[24]) begin
      m  = m >> 1;
      er = e + 10'sd1;
    end
    if (er >= EMAX)        r = {s, POS_INF[30:0]};
    else if (er <= 10'sd0) r = {s, 31'd0};
    else                   r = {s, er[7:0], m[22:0]};
    return r;
  endfunction

  logic        held_a, held_b;
  logic [31:0] hold_a, hold_b;
  logic        take_a, take_b, avail_a, avail_b, fire;
  logic [31:0] op_a, op_b;

  assign s_axis_a_tready = !held_a;
  assign s_axis_b_tready = !held_b;
  assign take_a  = s_axis_a_tvalid & !held_a;
  assign take_b  = s_axis_b_tvalid & !held_b;
  assign avail_a = held_a | take_a;
  assign avail_b = held_b | take_b;
  assign fire    = avail_a & avail_b;
  assign op_a    = held_a ? hold_a : s_axis_a_tdata;
  assign op_b    = held_b ? hold_b : s_axis_b_tdata;

  // Held flags: set when a lone channel arrives, cleared when the pair fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_a <= 1'b0;
      held_b <= 1'b0;
    end else if (fire) begin
      held_a <= 1'b0;
      held_b <= 1'b0;
    end else begin
      if (take_a) held_a <= 1'b1;
      if (take_b) held_b <= 1'b1;
    end
  end

  // Hold registers capture only an operand that cannot fire this cycle.
  always_ff @(posedge clk) begin
    if (take_a && !fire) hold_a <= s_axis_a_tdata;
    if (take_b && !fire) hold_b <= s_axis_b_tdata;
  end

  // ---- p0: joined operand pair ----
  logic [31:0] a_p0, b_p0;
  logic        vld_p0, vld_p1, vld_p2, vld_p3;

  // ---- S1: unpack, negate b, classify specials, order by magnitude ----
  fp32_unpacked_t ua, ub;
  logic        s1_special;
  logic [31:0] s1_spec;
  logic        s1_swap;

  // Operand decode; b's sign is flipped so the rest of the datapath is an adder.
  always_comb begin
    ua      = unpack(a_p0);
    ub      = unpack(b_p0);
    ub.sign = ~ub.sign;
  end

  // Special-case result, in priority order NaN, Inf-Inf, Inf, zero+zero.
  always_comb begin
    s1_special = 1'b1;
    s1_spec    = QNAN;
    if (ua.is_nan || ub.is_nan)                            s1_spec = QNAN;
    else if (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)) s1_spec = QNAN;
    else if (ua.is_inf)                                    s1_spec = ua.sign ? NEG_INF : POS_INF;
    else if (ub.is_inf)                                    s1_spec = ub.sign ? NEG_INF : POS_INF;
    else if (ua.is_zero && ub.is_zero)                     s1_spec = {ua.sign & ub.sign, 31'd0};
    else                                                   s1_special = 1'b0;
  end

  assign s1_swap = {ub.exp, ub.mant} > {ua.exp, ua.mant};

  logic              sx_p1, sub_p1, special_p1;
  logic [7:0]        ex_p1, ey_p1;
  logic [23:0]       mx_p1, my_p1;
  logic [31:0]       spec_p1;

  // ---- S2: align the smaller operand with guard/round/sticky ----
  logic [7:0]  d_s2;
  logic [53:0] sh_s2;
  logic [26:0] yal_s2;

  // Shift distances of 27 or more leave only the sticky bit.
  always_comb begin
    d_s2   = ex_p1 - ey_p1;
    sh_s2  = '0;
    yal_s2 = '0;
    if (d_s2 >= 8'd27) begin
      yal_s2 = {26'd0, |my_p1};
    end else begin
      sh_s2  = {my_p1, 3'b000, 27'd0} >> d_s2;
      yal_s2 = sh_s2[53:27] | {26'd0, |sh_s2[26:0]};
    end
  end

  logic        sx_p2, sub_p2, special_p2;
  logic [7:0]  ex_p2;
  logic [26:0] xext_p2, yal_p2;
  logic [31:0] spec_p2;

  // ---- S3: magnitude add/subtract and leading-zero count ----
  logic [27:0] sum_s3;
  logic [4:0]  lz_s3;

  assign sum_s3 = sub_p2 ? ({1'b0, xext_p2} - {1'b0, yal_p2})
                         : ({1'b0, xext_p2} + {1'b0, yal_p2});

  synthesijer_lzc28 u_lzc (
    .din (sum_s3),
    .cnt (lz_s3)
  );

  logic        sx_p3, special_p3;
  logic [7:0]  ex_p3;
  logic [27:0] sum_p3;
  logic [4:0]  lz_p3;
  logic [31:0] spec_p3;

  // ---- S4: normalize, round, pack ----
  logic [26:0]       n_s4;
  logic signed [9:0] e_s4;
  logic [31:0]       res_s4;

  // Carry out shifts right one place; cancellation shifts left to the hidden bit.
  always_comb begin
    if (lz_p3 == 5'd0) begin
      n_s4 = sum_p3[27:1] | {26'd0, sum_p3[0]};
      e_s4 = $signed({2'b00, ex_p3}) + 10'sd1;
    end else begin
      n_s4 = sum_p3[26:0] << (lz_p3 - 5'd1);
      e_s4 = $signed({2'b00, ex_p3}) - $signed({5'd0, lz_p3}) + 10'sd1;
    end
    if (special_p3)            res_s4 = spec_p3;
    else if (sum_p3 == 28'd0)  res_s4 = 32'd0;
    else                       res_s4 = round_pack(sx_p3, e_s4, n_s4);
  end

  // Pipeline valid bits; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p0 <= fire;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // Datapath stage registers, free-running without reset.
  always_ff @(posedge clk) begin
    a_p0       <= op_a;
    b_p0       <= op_b;

    sx_p1      <= s1_swap ? ub.sign : ua.sign;
    ex_p1      <= s1_swap ? ub.exp  : ua.exp;
    mx_p1      <= s1_swap ? ub.mant : ua.mant;
    ey_p1      <= s1_swap ? ua.exp  : ub.exp;
    my_p1      <= s1_swap ? ua.mant : ub.mant;
    sub_p1     <= ua.sign ^ ub.sign;
    special_p1 <= s1_special;
    spec_p1    <= s1_spec;

    sx_p2      <= sx_p1;
    ex_p2      <= ex_p1;
    xext_p2    <= {mx_p1, 3'b000};
    yal_p2     <= yal_s2;
    sub_p2     <= sub_p1;
    special_p2 <= special_p1;
    spec_p2    <= spec_p1;

    sx_p3      <= sx_p2;
    ex_p3      <= ex_p2;
    sum_p3     <= sum_s3;
    lz_p3      <= lz_s3;
    special_p3 <= special_p2;
    spec_p3    <= spec_p2;
  end

  // Output register: one-cycle strobe, data held between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_result_tvalid <= 1'b0;
      m_axis_result_tdata  <= 32'd0;
    end else begin
      m_axis_result_tvalid <= vld_p3;
      if (vld_p3) m_axis_result_tdata <= res_s4;
    end
  end

endmodule

// File: tb/tb_synthesijer_fsub32_core.sv
// Self-checking bench for synthesijer_fsub32_core.
module tb_synthesijer_fsub32_core;
  import synthesijer_fp32_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_tdata, b_tdata, r_tdata;
  logic        a_tvalid, b_tvalid, a_tready, b_tready, r_tvalid;

  int errors = 0;
  int checks = 0;

  synthesijer_fsub32_core dut (
    .clk                  (clk),
    .reset                (reset),
    .s_axis_a_tdata       (a_tdata),
    .s_axis_a_tvalid      (a_tvalid),
    .s_axis_a_tready      (a_tready),
    .s_axis_b_tdata       (b_tdata),
    .s_axis_b_tvalid      (b_tvalid),
    .s_axis_b_tready      (b_tready),
    .m_axis_result_tdata  (r_tdata),
    .m_axis_result_tvalid (r_tvalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, req);
    end
  endtask

  // Reference conversions through double precision (exact for small exponent spreads).
  function automatic real to_real(input logic [31:0] v);
    logic [10:0] e11;
    e11 = {3'b000, v[30:23]} + 11'd896;
    return $bitstoreal({v[31], e11, v[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] to_single(input real r);
    logic [63:0] bits;
    logic [52:0] m53;
    logic [24:0] m;
    logic        up;
    int          e;
    bits = $realtobits(r);
    if (bits[62:0] == 63'd0) return {bits[63], 31'd0};
    e   = int'(bits[62:52]) - 896;
    m53 = {1'b1, bits[51:0]};
    up  = m53[28] & ((|m53[27:0]) | m53[29]);
    m   = {1'b0, m53[52:29]} + {24'd0, up};
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {bits[63], 31'h7F800000};
    if (e <= 0)   return {bits[63], 31'd0};
    return {bits[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_normal();
    logic [7:0]  e;
    logic [31:0] f;
    e = 8'($urandom_range(120, 134));
    f = $urandom;
    return {1'($urandom_range(0, 1)), e, f[22:0]};
  endfunction

  // Apply one pair in a single cycle and expect exactly one strobe LATENCY edges later.
  task automatic run_vec(input int idx);
    logic early;
    early    = 1'b0;
    a_tdata  = vecs[idx].a;
    b_tdata  = vecs[idx].b;
    a_tvalid = 1'b1;
    b_tvalid = 1'b1;
    tick();
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    for (int c = 1; c < LATENCY; c++) begin
      tick();
      if (r_tvalid) early = 1'b1;
    end
    chk($sformatf("vec%0d_early", idx), {31'd0, early}, 32'd0);
    tick();
    chk($sformatf("vec%0d_valid", idx), {31'd0, r_tvalid}, 32'd1);
    chk($sformatf("vec%0d_data", idx), r_tdata, vecs[idx].exp);
    tick();
    chk($sformatf("vec%0d_once", idx), {31'd0, r_tvalid}, 32'd0);
  endtask

  logic [31:0] ta [16];
  logic [31:0] tb [16];
  logic [31:0] te [16];

  initial begin
    vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000}; // 3 - 1
    vecs[1]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000}; // Inf - Inf
    vecs[2]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000}; // overflow
    vecs[3]  = '{32'h80000000, 32'h00000000, 32'h80000000}; // -0 - +0
    vecs[4]  = '{32'h3F800000, 32'h33000000, 32'h3F800000}; // RNE tie
    vecs[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000}; // NaN in
    vecs[6]  = '{32'h3F800000, 32'h7F800000, 32'hFF800000}; // 1 - Inf
    vecs[7]  = '{32'hFF800000, 32'h7F800000, 32'hFF800000}; // -Inf - Inf
    vecs[8]  = '{32'h3F800000, 32'h3F800000, 32'h00000000}; // exact cancel
    vecs[9]  = '{32'h00000001, 32'h00000000, 32'h00000000}; // denormal flushed
    vecs[10] = '{32'h00000000, 32'h3F800000, 32'hBF800000}; // 0 - 1
    vecs[11] = '{32'h00800001, 32'h00800000, 32'h00000000}; // underflow FTZ
    vecs[12] = '{32'h3FC00000, 32'hC0200000, 32'h40800000}; // 1.5 - -2.5
    vecs[13] = '{32'h7F000000, 32'hFF000000, 32'h7F800000}; // 2^127 + 2^127
    vecs[14] = '{32'h40000000, 32'h40400000, 32'hBF800000}; // 2 - 3

    a_tdata  = 32'd0;
    b_tdata  = 32'd0;
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    chk("rst_tvalid", {31'd0, r_tvalid}, 32'd0);
    chk("rst_tdata", r_tdata, 32'd0);
    chk("rst_a_tready", {31'd0, a_tready}, 32'd1);
    chk("rst_b_tready", {31'd0, b_tready}, 32'd1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) run_vec(i);

    // Join: a arrives alone, is held; a second a is refused until b completes the pair.
    a_tdata  = 32'h3F800000;
    a_tvalid = 1'b1;
    tick();
    chk("join_a_held_tready", {31'd0, a_tready}, 32'd0);
    a_tdata = 32'h40000000;
    tick();
    chk("join_no_strobe1", {31'd0, r_tvalid}, 32'd0);
    tick();
    chk("join_still_held", {31'd0, a_tready}, 32'd0);
    a_tvalid = 1'b0;
    b_tdata  = 32'h3F800000;
    b_tvalid = 1'b1;
    tick();
    b_tvalid = 1'b0;
    chk("join_released_tready", {31'd0, a_tready}, 32'd1);
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk($sformatf("join_strobe_c%0d", c), {31'd0, r_tvalid}, (c == LATENCY) ? 32'd1 : 32'd0);
      if (c == LATENCY) chk("join_data", r_tdata, 32'h00000000);
    end

    // Throughput: 16 back-to-back pairs against the real-arithmetic model.
    for (int i = 0; i < 16; i++) begin
      ta[i] = rnd_normal();
      tb[i] = rnd_normal();
      te[i] = to_single(to_real(ta[i]) - to_real(tb[i]));
    end
    for (int c = 0; c < 22; c++) begin
      if (c < 16) begin
        a_tdata  = ta[c];
        b_tdata  = tb[c];
        a_tvalid = 1'b1;
        b_tvalid = 1'b1;
      end else begin
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
      end
      tick();
      chk($sformatf("thr_valid_c%0d", c), {31'd0, r_tvalid},
          (c >= LATENCY && c < LATENCY + 16) ? 32'd1 : 32'd0);
      if (c >= LATENCY && c < LATENCY + 16)
        chk($sformatf("thr_data%0d", c - LATENCY), r_tdata, te[c - LATENCY]);
    end

    // Reset mid-flight: three ops fire, a lone a is held, then reset drops it all.
    for (int c = 0; c < 3; c++) begin
      a_tdata  = 32'h40400000;
      b_tdata  = 32'h3F800000;
      a_tvalid = 1'b1;
      b_tvalid = 1'b1;
      tick();
      chk($sformatf("rmf_quiet_c%0d", c), {31'd0, r_tvalid}, 32'd0);
    end
    b_tvalid = 1'b0;
    tick();
    a_tvalid = 1'b0;
    chk("rmf_a_held", {31'd0, a_tready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmf_tvalid", {31'd0, r_tvalid}, 32'd0);
    chk("rmf_tdata", r_tdata, 32'd0);
    chk("rmf_a_tready", {31'd0, a_tready}, 32'd1);
    chk("rmf_b_tready", {31'd0, b_tready}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("rmf_no_strobe_c%0d", c), {31'd0, r_tvalid}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/synthesijer_fsub32_core.md
Name: synthesijer_fsub32_core

Overview:
Native RTL IEEE-754 single-precision subtractor (result = a - b). It implements the responder side of the fsub32_ip AXI-Stream operand/result interface, so it is a vendor-independent drop-in for the synthesijer_fsub32 wrapper. It joins two independent operand channels, runs a fixed 4-stage pipeline and emits one result per accepted operand pair.

Parameters:
none. LATENCY=4 is a package constant, not overridable.

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
s_axis_a_tdata  in  32  operand a (minuend)
s_axis_a_tvalid  in  1  operand a valid
s_axis_a_tready  out  1  operand a accepted when tvalid&tready
s_axis_b_tdata  in  32  operand b (subtrahend)
s_axis_b_tvalid  in  1  operand b valid
s_axis_b_tready  out  1  operand b accepted when tvalid&tready
m_axis_result_tdata  out  32  a - b
m_axis_result_tvalid  out  1  one-cycle result strobe; no tready, no backpressure

Behaviour:
- Reset: clock is clk, reset is synchronous active-high. Clears both operand hold flags, all pipeline valid bits, m_axis_result_tvalid=0 and m_axis_result_tdata=0. In-flight operations are discarded with no result. Datapath registers other than the output are not reset.
- Join:
  - Per channel: hold register plus held flag; tready = !held.
  - A channel is "available" when held, or when tvalid&tready.
  - fire = avail_a & avail_b. The held value takes priority over the input.
  - On fire: both held flags clear.
  - If exactly one channel is available, that channel captures into its hold (held=1).
  - Both valid in the same cycle with nothing held: fire immediately, nothing held.
  - Held channel with new tvalid: not accepted (tready=0) until the pair fires.
- Pipeline: throughput 1 op/cycle. If fire is sampled at edge k, m_axis_result_tvalid=1 for exactly the cycle following edge k+4. Result order equals fire order.
  - S1: unpack, flip b sign, flush denormal inputs to signed zero, classify NaN/Inf/zero, swap so |x|>=|y|.
  - S2: align y by exponent difference, with guard/round/sticky. Shifts >=27 collapse to sticky only.
  - S3: 28-bit add/subtract of magnitudes; leading-zero count.
  - S4: normalize, round to nearest even, detect overflow/underflow, pack.
- Special cases (precedence top-down):
  - Any NaN input -> 0x7FC00000 (canonical qNaN).
  - +Inf - +Inf or -Inf - -Inf -> 0x7FC00000.
  - Inf operand -> that Inf with the effective sign.
  - Exact zero result -> +0, except (-0)-(+0) -> 0x80000000.
  - Exponent overflow after rounding -> signed Inf.
  - Result below min normal -> signed zero (flush-to-zero).
- Rounding carry into a new exponent is handled in S4; mantissa overflow 0x1000000 renormalizes.

Decomposition:
- Package synthesijer_fp32_pkg holds:
  - constants: LATENCY=4, EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, POS_INF, NEG_INF.
  - typedef fp32_unpacked_t: sign, exp[7:0], mant[23:0], is_nan, is_inf, is_zero.
  - function unpack.
- One sub-module: synthesijer_lzc28, a combinational 28-bit leading-zero counter returning 5 bits, instantiated in S3.

Test Plan:
- Basic: a=0x40400000 (3.0) and b=0x3F800000 (1.0) valid together -> result 0x40000000 exactly 4 cycles later; tvalid high 1 cycle.
- Join: a=0x3F800000 presented 3 cycles before b=0x3F800000 -> a_tready drops after capture; one result 0x00000000, 4 cycles after b's cycle; no extra strobe.
- Specials:
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000.
  - 0x7F7FFFFF - 0xFF7FFFFF -> 0x7F800000.
  - 0x80000000 - 0x00000000 -> 0x80000000.
- Rounding tie: 0x3F800000 - 0x33000000 (1 - 2^-25) -> 0x3F800000 (RNE to even).
- Throughput: 16 back-to-back random normal pairs on consecutive cycles -> 16 consecutive strobes in order, bit-exact versus reference model (FTZ, RNE).
- Reset mid-flight: fire 3 ops, assert reset 2 cycles later for 1 cycle -> no result strobes; tdata=0; tready=1 on both channels the cycle after reset.
